// File: rtl/obc_da_bin_engine_pkg.sv
// Shared types and width helpers for the offset-binary DA bin engine.
package obc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Fixed-point position of the coefficient binary point (Q10.21).
    localparam int unsigned FRAC_W = 21;

    // Accumulator width: coefficient + sample + adder-tree growth + OBC sign bit.
    function automatic int unsigned acc_width(input int unsigned n_pairs,
                                              input int unsigned data_w,
                                              input int unsigned coef_w);
        return coef_w + data_w + $clog2(n_pairs) + 1;
    endfunction

endpackage

// File: rtl/obc_da_bin_engine_if.sv
// Frame-in / result-out stream bundle of the DA bin engine.
interface obc_da_bin_engine_if
    import obc_pkg::*;
#(
    parameter int unsigned N_PAIRS = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = acc_width(N_PAIRS, DATA_W, 32)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [2*N_PAIRS*DATA_W-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_W-1:0]            out_data;

    // Upstream frame source and downstream result sink.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The engine itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/obc_da_bin_engine_pair_rom.sv
// One sample pair: 2-entry writable coefficient table, XOR select and
// conditional negate, producing the sign-extended partial term.
module obc_pair_rom #(
    parameter int unsigned COEF_W = 32,
    parameter int unsigned ACC_W  = 52
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              sel_addr,
    input  logic [COEF_W-1:0] wdata,
    input  logic              xa,
    input  logic              xb,
    output logic [ACC_W-1:0]  term
);
    logic [COEF_W-1:0] coef_q [2];
    logic [COEF_W-1:0] coef_d [2];
    logic              sel;
    logic [ACC_W-1:0]  mag;

    // Table write port.
    always_comb begin
        coef_d[0] = coef_q[0];
        coef_d[1] = coef_q[1];
        if (we) begin
            coef_d[sel_addr] = wdata;
        end
    end

    // Coefficient storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q[0] <= '0;
            coef_q[1] <= '0;
        end else begin
            coef_q[0] <= coef_d[0];
            coef_q[1] <= coef_d[1];
        end
    end

    // Pick sum/difference coefficient, sign by the first sample bit.
    always_comb begin
        sel  = xa ^ xb;
        mag  = {{(ACC_W-COEF_W){coef_q[sel][COEF_W-1]}}, coef_q[sel]};
        term = xa ? mag : -mag;
    end

endmodule

// File: rtl/obc_da_bin_engine.sv
// Bit-serial offset-binary DA engine computing one DFT bin component
// from a runtime-loaded coefficient table and offset constant.
module obc_da_bin_engine
    import obc_pkg::*;
#(
    parameter int unsigned N_PAIRS = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned COEF_W  = 32,
    parameter int unsigned ACC_W   = acc_width(N_PAIRS, DATA_W, COEF_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(N_PAIRS):0] cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic                     cfg_off_we,
    input  logic [ACC_W-1:0]         cfg_off_data,
    output logic                     cfg_err,
    obc_da_bin_engine_if.slave       bus,
    output logic                     busy
);
    localparam int unsigned     PIDX_W = $clog2(N_PAIRS);
    localparam int unsigned     B_W    = $clog2(DATA_W);
    localparam logic [B_W-1:0]  B_MSB  = B_W'(DATA_W - 1);
    localparam int unsigned     X_W    = 2 * N_PAIRS * DATA_W;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] off_q, off_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;
    logic             accept, cfg_ok, coef_wr;
    logic [ACC_W-1:0] psum;
    logic [ACC_W-1:0] term [N_PAIRS];

    assign accept  = in_ready_q && bus.in_valid;
    assign cfg_ok  = (state_q == IDLE) && !accept;
    assign coef_wr = cfg_we && cfg_ok;

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        logic [DATA_W-1:0] xa;
        logic [DATA_W-1:0] xb;
        assign xa = x_q[2*p*DATA_W +: DATA_W];
        assign xb = x_q[(2*p+1)*DATA_W +: DATA_W];

        obc_pair_rom #(
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_rom (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (coef_wr && (cfg_addr[PIDX_W:1] == PIDX_W'(p))),
            .sel_addr (cfg_addr[0]),
            .wdata    (cfg_data),
            .xa       (xa[b_q]),
            .xb       (xb[b_q]),
            .term     (term[p])
        );
    end

    // Adder tree over all pair terms for the current bit plane.
    always_comb begin
        psum = '0;
        for (int unsigned p = 0; p < N_PAIRS; p++) begin
            psum = psum + term[p];
        end
    end

    // FSM and datapath next-state; the MSB plane carries negative weight.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        b_d         = b_q;
        acc_d       = acc_q;
        off_d       = off_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        cfg_err_d   = (cfg_we || cfg_off_we) && !cfg_ok;

        if (cfg_off_we && cfg_ok) begin
            off_d = cfg_off_data;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d        = bus.in_data;
                    acc_d      = '0;
                    b_d        = B_MSB;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                acc_d = (acc_q << 1) + ((b_q == B_MSB) ? -psum : psum);
                b_d   = b_q - B_W'(1);
                if (b_q == '0) begin
                    state_d     = DONE;
                    out_data_d  = acc_d + off_q;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            off_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            off_q       <= off_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_obc_da_bin_engine.sv
// Directed and reference-model bench for the DA bin engine: a 4-bit
// instance for hand-computed vectors and corner sequences, a 16-bit
// instance for DFT bin-3 imaginary frames.
module tb_obc_da_bin_engine;
    import obc_pkg::*;

    localparam int unsigned NP   = 8;
    localparam int unsigned CW   = 32;
    localparam int unsigned SW   = 4;
    localparam int unsigned LW   = 16;
    localparam int unsigned SACC = acc_width(NP, SW, CW);
    localparam int unsigned LACC = acc_width(NP, LW, CW);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic            s_cfg_we, s_cfg_off_we, s_cfg_err, s_busy;
    logic [3:0]      s_cfg_addr;
    logic [CW-1:0]   s_cfg_data;
    logic [SACC-1:0] s_cfg_off_data;
    logic            l_cfg_we, l_cfg_off_we, l_cfg_err, l_busy;
    logic [3:0]      l_cfg_addr;
    logic [CW-1:0]   l_cfg_data;
    logic [LACC-1:0] l_cfg_off_data;

    obc_da_bin_engine_if #(.N_PAIRS(NP), .DATA_W(SW), .ACC_W(SACC)) s_if ();
    obc_da_bin_engine_if #(.N_PAIRS(NP), .DATA_W(LW), .ACC_W(LACC)) l_if ();

    obc_da_bin_engine #(.N_PAIRS(NP), .DATA_W(SW), .COEF_W(CW)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr),
        .cfg_data(s_cfg_data), .cfg_off_we(s_cfg_off_we), .cfg_off_data(s_cfg_off_data),
        .cfg_err(s_cfg_err), .bus(s_if), .busy(s_busy)
    );

    obc_da_bin_engine #(.N_PAIRS(NP), .DATA_W(LW), .COEF_W(CW)) dut_l (
        .clk(clk), .rst_n(rst_n), .cfg_we(l_cfg_we), .cfg_addr(l_cfg_addr),
        .cfg_data(l_cfg_data), .cfg_off_we(l_cfg_off_we), .cfg_off_data(l_cfg_off_data),
        .cfg_err(l_cfg_err), .bus(l_if), .busy(l_busy)
    );

    typedef struct {
        logic [3:0] x0;
        logic [3:0] x1;
        logic [3:0] rest;
        longint     off;
        longint     exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] m40(input longint v);
        logic [63:0] t;
        t = v;
        return {24'd0, t[39:0]};
    endfunction

    function automatic logic [63:0] m52(input longint v);
        logic [63:0] t;
        t = v;
        return {12'd0, t[51:0]};
    endfunction

    function automatic logic [63:0] s_pack(input logic [3:0] x0, input logic [3:0] x1,
                                           input logic [3:0] rest);
        logic [63:0] f;
        for (int unsigned k = 0; k < 16; k++) f[k*4 +: 4] = rest;
        f[3:0] = x0;
        f[7:4] = x1;
        return f;
    endfunction

    task automatic s_wr_coef(input logic [3:0] addr, input logic [CW-1:0] data);
        s_cfg_addr = addr;
        s_cfg_data = data;
        s_cfg_we   = 1'b1;
        tick();
        s_cfg_we   = 1'b0;
    endtask

    task automatic s_wr_off(input longint v);
        s_cfg_off_data = SACC'(v);
        s_cfg_off_we   = 1'b1;
        tick();
        s_cfg_off_we   = 1'b0;
    endtask

    task automatic l_wr_coef(input logic [3:0] addr, input logic [CW-1:0] data);
        l_cfg_addr = addr;
        l_cfg_data = data;
        l_cfg_we   = 1'b1;
        tick();
        l_cfg_we   = 1'b0;
    endtask

    // Bounded wait for the small instance result; returns cycles waited.
    task automatic s_wait(output int unsigned n);
        n = 0;
        while (!s_if.out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic s_handshake(input string name);
        s_if.out_ready = 1'b1;
        tick();
        s_if.out_ready = 1'b0;
        check({name, " out_valid drop"}, 64'(s_if.out_valid), 64'd0);
    endtask

    task automatic s_frame(input logic [63:0] frame, input longint exp, input string name);
        int unsigned n;
        check({name, " in_ready"}, 64'(s_if.in_ready), 64'd1);
        s_if.in_data  = frame;
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        s_wait(n);
        check({name, " latency"}, 64'(n), 64'(SW));
        check({name, " out_data"}, 64'(s_if.out_data), m40(exp));
        s_handshake(name);
    endtask

    task automatic l_frame(input logic [255:0] frame, input longint exp, input string name);
        int unsigned n;
        l_if.in_data  = frame;
        l_if.in_valid = 1'b1;
        tick();
        l_if.in_valid = 1'b0;
        n = 0;
        while (!l_if.out_valid && n < 60) begin
            tick();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(LW));
        check({name, " out_data"}, 64'(l_if.out_data), m52(exp));
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        longint      sv [16];
        longint      c [16];
        longint      osum;
        longint      h0, h1, y;
        logic [255:0] fr;
        logic [15:0]  smp;

        s_cfg_we = 0; s_cfg_off_we = 0; s_cfg_addr = '0; s_cfg_data = '0; s_cfg_off_data = '0;
        l_cfg_we = 0; l_cfg_off_we = 0; l_cfg_addr = '0; l_cfg_data = '0; l_cfg_off_data = '0;
        s_if.in_valid = 0; s_if.in_data = '0; s_if.out_ready = 0;
        l_if.in_valid = 0; l_if.in_data = '0; l_if.out_ready = 1;

        vecs[0] = '{4'h1, 4'h0, 4'h0,    0,   240};
        vecs[1] = '{4'h0, 4'h0, 4'h0, -100,     0};
        vecs[2] = '{4'h8, 4'h0, 4'h0,    0, -1020};
        vecs[3] = '{4'h7, 4'h7, 4'h0,    0,  1500};
        vecs[4] = '{4'hF, 4'h8, 4'h0,    5,  -515};
        vecs[5] = '{4'h3, 4'hE, 4'h0, -100,   300};
        vecs[6] = '{4'h8, 4'h7, 4'h0,    0,  -600};
        vecs[7] = '{4'h2, 4'h5, 4'hF,    0,   680};

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        check("rst in_ready", 64'(s_if.in_ready), 64'd1);
        check("rst out_valid", 64'(s_if.out_valid), 64'd0);
        check("rst out_data", 64'(s_if.out_data), 64'd0);
        check("rst busy", 64'(s_busy), 64'd0);
        check("rst cfg_err", 64'(s_cfg_err), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven frames: C[0][0]=100, C[0][1]=40, everything else 0.
        s_wr_coef(4'd0, 32'd100);
        s_wr_coef(4'd1, 32'd40);
        check("cfg write no err", 64'(s_cfg_err), 64'd0);
        for (int unsigned i = 0; i < 8; i++) begin
            s_wr_off(vecs[i].off);
            s_frame(s_pack(vecs[i].x0, vecs[i].x1, vecs[i].rest), vecs[i].exp,
                    $sformatf("vec%0d", i));
        end
        s_wr_off(0);

        // Backpressure with in_valid held high throughout.
        s_if.in_data  = s_pack(4'h1, 4'h0, 4'h0);
        s_if.in_valid = 1'b1;
        tick();
        s_wait(n);
        check("bp latency", 64'(n), 64'(SW));
        for (int unsigned i = 0; i < 10; i++) begin
            check("bp out_valid hold", 64'(s_if.out_valid), 64'd1);
            check("bp out_data hold", 64'(s_if.out_data), m40(240));
            check("bp in_ready low", 64'(s_if.in_ready), 64'd0);
            tick();
        end
        s_if.out_ready = 1'b1;
        tick();
        s_if.out_ready = 1'b0;
        check("bp out_valid drop", 64'(s_if.out_valid), 64'd0);
        check("bp in_ready after hs", 64'(s_if.in_ready), 64'd1);
        check("bp busy after hs", 64'(s_busy), 64'd0);
        tick();
        s_if.in_valid = 1'b0;
        check("bp reaccept in_ready", 64'(s_if.in_ready), 64'd0);
        check("bp reaccept busy", 64'(s_busy), 64'd1);
        s_wait(n);
        check("bp second out_data", 64'(s_if.out_data), m40(240));
        s_handshake("bp second");

        // Config writes during RUN are dropped.
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        tick();
        s_cfg_addr = 4'd0; s_cfg_data = 32'd999; s_cfg_off_data = SACC'(12345);
        s_cfg_we = 1'b1; s_cfg_off_we = 1'b1;
        tick();
        s_cfg_we = 1'b0; s_cfg_off_we = 1'b0;
        check("run cfg_err pulse", 64'(s_cfg_err), 64'd1);
        tick();
        check("run cfg_err clear", 64'(s_cfg_err), 64'd0);
        s_wait(n);
        check("run cfg out_data", 64'(s_if.out_data), m40(240));
        s_handshake("run cfg");

        // Config write together with frame accept: accept wins.
        s_cfg_addr = 4'd0; s_cfg_data = 32'd555;
        s_if.in_valid = 1'b1; s_cfg_we = 1'b1;
        tick();
        s_if.in_valid = 1'b0; s_cfg_we = 1'b0;
        check("accept cfg_err", 64'(s_cfg_err), 64'd1);
        check("accept busy", 64'(s_busy), 64'd1);
        s_wait(n);
        check("accept cfg out_data", 64'(s_if.out_data), m40(240));
        s_handshake("accept cfg");

        // Coefficient and offset written in the same IDLE cycle.
        s_cfg_addr = 4'd1; s_cfg_data = 32'd60; s_cfg_off_data = SACC'(-100);
        s_cfg_we = 1'b1; s_cfg_off_we = 1'b1;
        tick();
        s_cfg_we = 1'b0; s_cfg_off_we = 1'b0;
        check("dual cfg_err", 64'(s_cfg_err), 64'd0);
        s_frame(s_pack(4'h1, 4'h0, 4'h0), 160, "dual");
        s_wr_coef(4'd1, 32'd40);
        s_wr_off(0);

        // Reset in RUN cycle 2.
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun in_ready", 64'(s_if.in_ready), 64'd1);
        check("midrun out_valid", 64'(s_if.out_valid), 64'd0);
        check("midrun out_data", 64'(s_if.out_data), 64'd0);
        check("midrun busy", 64'(s_busy), 64'd0);
        for (int unsigned i = 0; i < 6; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            check("midrun no out_valid", 64'(s_if.out_valid), 64'd0);
        end
        s_frame(s_pack(4'h1, 4'h0, 4'h0), 0, "cleared table");
        s_wr_coef(4'd0, 32'd100);
        s_wr_coef(4'd1, 32'd40);
        s_frame(s_pack(4'h1, 4'h0, 4'h0), 240, "reload");

        // Bin-3 imaginary part of a 16-point DFT, coefficients -sin in Q10.21.
        sv = '{0, 401273, 741455, 968758, 1048576, 968758, 741455, 401273,
               0, -401273, -741455, -968758, -1048576, -968758, -741455, -401273};
        for (int unsigned k = 0; k < 16; k++) c[k] = -2 * sv[(3*k) % 16];
        osum = 0;
        for (int unsigned p = 0; p < NP; p++) begin
            h0 = (c[2*p] + c[2*p+1]) / 2;
            h1 = (c[2*p] - c[2*p+1]) / 2;
            l_wr_coef(4'(2*p), CW'(h0));
            l_wr_coef(4'(2*p+1), CW'(h1));
            osum = osum - h0;
        end
        l_cfg_off_data = LACC'(osum);
        l_cfg_off_we   = 1'b1;
        tick();
        l_cfg_off_we   = 1'b0;

        for (int unsigned f = 0; f < 1000; f++) begin
            y = 0;
            for (int unsigned k = 0; k < 16; k++) begin
                if (f == 0)      smp = 16'h8000;
                else if (f == 1) smp = 16'h7FFF;
                else if (f == 2) smp = k[0] ? 16'h8000 : 16'h7FFF;
                else             smp = 16'($urandom);
                fr[k*16 +: 16] = smp;
                y = y + c[k] * longint'($signed(smp));
            end
            l_frame(fr, y, $sformatf("dft frame %0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obc_da_bin_engine.md
Name: obc_da_bin_engine

Overview:
- Sequential, programmable successor to the fixed per-bin OBC coefficient ROMs.
- Computes one DFT output component (real or imaginary part of one bin) from 2*N_PAIRS two's-complement samples by bit-serial offset-binary distributed arithmetic.
- The coefficient table is loaded at run time instead of hard-wired, so one instance serves any bin/part of any N-point DFT.
- Sits between the sample frame buffer (valid/ready in) and the bin result collector (valid/ready out).

Parameters:
- N_PAIRS, 8: number of sample pairs; the block processes 2*N_PAIRS samples per frame.
- DATA_W, 16: sample width, two's complement.
- COEF_W, 32: coefficient width, signed fixed point (1 sign, 10 integer, 21 fraction).
- ACC_W, COEF_W+DATA_W+$clog2(N_PAIRS)+1: accumulator and result width.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  coefficient-table write strobe.
- cfg_addr  in  $clog2(N_PAIRS)+1  coefficient address; {pair index, sel}, where sel is the LSB.
- cfg_data  in  COEF_W  coefficient value.
- cfg_off_we  in  1  offset-register write strobe.
- cfg_off_data  in  ACC_W  offset value.
- cfg_err  out  1  one-cycle pulse: a config write was dropped.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- in_data  in  2*N_PAIRS*DATA_W  samples; x_k = in_data[k*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, out_data=0, busy=0, cfg_err=0.
  - All coefficients, the offset register and the accumulator clear to 0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the sample register, clear acc, set bit counter b=DATA_W-1, go to RUN.
- RUN (exactly DATA_W cycles, MSB first):
  - Per pair p:
    - sel_p = x_{2p}[b] ^ x_{2p+1}[b].
    - term_p = x_{2p}[b] ? +C[p][sel_p] : -C[p][sel_p].
  - P = sum over p of term_p, sign-extended to ACC_W.
  - acc <= (acc<<1) + (b==DATA_W-1 ? -P : +P).
  - b decrements each cycle. After the b==0 cycle, go to DONE.
- DONE:
  - out_data = acc + offset is registered on entry; out_valid=1.
  - Result and out_valid hold until out_ready=1.
  - On out_valid&&out_ready: out_valid drops next cycle, return to IDLE.
- Latency: frame accept to out_valid is DATA_W+1 cycles. Throughput is one frame per DATA_W+2 cycles with out_ready tied high.
- in_ready is 0 in RUN and DONE. in_valid there is ignored; the upstream holds it.
- Arithmetic:
  - All sums are in ACC_W two's complement and wrap modulo 2^ACC_W. There is no saturation.
  - Coefficients are stored pre-halved (c/2) by software. The offset register carries the OBC constant term.
- Config writes:
  - Accepted only when state==IDLE and no frame is accepted that same cycle. They take effect from the next cycle.
  - A cfg_we or cfg_off_we arriving otherwise is dropped, and cfg_err pulses high for 1 cycle.
  - A frame accept together with a config write: the accept wins, the write is dropped, and cfg_err pulses.
  - cfg_we and cfg_off_we together in IDLE: both writes are applied.
- Reset mid-RUN or mid-DONE: the frame is abandoned, there is no out_valid, and the table and offset clear.

Decomposition:
- Package obc_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam FRAC_W=21;
  - a function computing ACC_W from N_PAIRS, DATA_W and COEF_W.
- Sub-module obc_pair_rom, instantiated N_PAIRS times. Each instance contains:
  - a 2-entry COEF_W register table with a write port;
  - the XOR select;
  - a conditional negate producing term_p, sign-extended to ACC_W.
- The top holds the FSM, sample register, counter, adder tree, accumulator and offset.

Test Plan:
- Bench configuration for all scenarios except the last: DATA_W=4, N_PAIRS=8.
- Single-term frame: C[0][0]=100, C[0][1]=40, all other coefficients 0, offset 0; x0=1, all other samples 0 -> out_data=240 after 5 cycles.
- Offset cancel: same table, offset=-100; all samples 0 -> out_data=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable and in_ready=0 throughout; in_valid held high is accepted only one cycle after the handshake.
- Config protection: cfg_we during RUN -> cfg_err pulses 1 cycle, result unchanged (240); cfg_we asserted together with a frame accept -> dropped, cfg_err=1.
- Reset mid-RUN: drop rst_n at RUN cycle 2 -> outputs return to reset values immediately, out_valid never asserts; reload the table, rerun -> correct result.
- Random (DATA_W=16, N_PAIRS=8):
  - load DFT bin-3 imaginary coefficients (halved) plus the OBC offset;
  - run 1000 random frames against a reference-model DFT;
  - results must match bit-exactly modulo 2^ACC_W.
